// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state codes,
// default operand width and bit-counter width derivation.
package serial_add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int unsigned DEF_WIDTH = 8;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit generate/propagate full-adder cell; purely combinational.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum_c,
    output logic cout_c
);

    logic g;
    logic p;

    assign g      = a & b;
    assign p      = a ^ b;
    assign sum_c  = p ^ ci;
    assign cout_c = g | (p & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder time-sharing one fa_cell, LSB first.
// Define SERIAL_ADD_SUB_EN to honour in_sub (a - b as a + ~b + 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             sub_c;
    logic             accept_c;
    logic             last_c;
    logic             cell_s_c;
    logic             cell_co_c;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_c = in_sub;
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    assign sub_c      = 1'b0;
`endif

    fa_cell u_cell (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .ci     (carry),
        .sum_c  (cell_s_c),
        .cout_c (cell_co_c)
    );

    assign accept_c = in_valid && in_ready;
    assign last_c   = (cnt == CNT_W'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_c) next_state = RUN;
            RUN:     if (last_c) next_state = DONE;
            DONE:    if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake flags are registered decodes of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            busy      <= (next_state != IDLE);
        end
    end

    // Operand/sum shifters, carry flop and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            if (state == IDLE && accept_c) begin
                a_sh   <= in_a;
                b_sh   <= sub_c ? ~in_b : in_b;
                carry  <= sub_c ? 1'b1 : in_cin;
                cnt    <= '0;
                sum_sh <= '0;
            end else if (state == RUN) begin
                a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                sum_sh <= {cell_s_c, sum_sh[WIDTH-1:1]};
                carry  <= cell_co_c;
                cnt    <= cnt + CNT_W'(1);
                if (last_c) begin
                    out_sum  <= {cell_s_c, sum_sh[WIDTH-1:1]};
                    out_cout <= cell_co_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed and random adds
// against an arithmetic reference; honours SERIAL_ADD_SUB_EN when defined.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;
    bit   track_busy = 1'b1;
    bit   prev_valid = 1'b0;
    exp_t q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer readiness toggles away from both edges when randomised.
    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (track_busy) check("busy", 32'(busy), 32'(q.size() != 0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!prev_valid) check("latency", 32'(cyc - q[0].acc), 32'(W));
                    check("out_sum", 32'(out_sum), 32'(q[0].sum));
                    check("out_cout", 32'(out_cout), 32'(q[0].cout));
                    check("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Reference: plain (W+1)-bit arithmetic.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W:0] r;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`else
        r = {1'b0, a} + {1'b0, b} + (W+1)'(cin) + (W+1)'(sub & 1'b0);
`endif
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input bit push);
        int   n = 0;
        logic [W:0] r;
        exp_t e;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom);
        in_cin = 1'($urandom); in_sub = 1'($urandom);
        if (push) begin
            r = ref_add(a, b, cin, sub);
            e.sum = r[W-1:0];
            e.cout = r[W];
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic and wrap-around adds
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        drain();
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        drain();
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: hold the result for five cycles
        out_ready = 1'b0;
        do_op(8'h37, 8'hC4, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 40 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        check("bp_queue_empty", 32'(q.size()), 32'd0);

        // Busy rejection: a second request mid-RUN must be ignored
        do_op(8'h9B, 8'h2E, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
        check("run_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("reject_no_extra", 32'(busy), 32'd0);

        // Reset mid-RUN aborts immediately
        track_busy = 1'b0;
        do_op(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_sum", 32'(out_sum), 32'd0);
        check("abort_out_cout", 32'(out_cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        track_busy = 1'b1;
        @(posedge clk); #1;
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        drain();

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
        drain();
        do_op(8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
        drain();
`endif

        // Randomised traffic with a stalling consumer
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one 1-bit carry-lookahead full-adder cell (G = A&B, P = A^B) across a WIDTH-bit add.
- Latches operands on a valid/ready input handshake and steps the cell LSB-first, one bit per clock.
- Carry is held in a flop between steps; the assembled sum and carry-out are returned on a valid/ready output handshake.
- Used where area matters more than throughput.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in for bit 0.
- in_sub  input  1  subtract request; effective only with SERIAL_ADD_SUB_EN.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry-out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; out_sum=0; out_cout=0; bit counter=0; carry flop=0; operand shift registers=0.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a_sh=in_a, b_sh=in_b (inverted if subtracting), carry=in_cin (1 if subtracting), cnt=0, sum_sh=0; go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, the cell sees a_sh[0], b_sh[0], carry.
  - On the edge: sum bit shifts into sum_sh MSB and sum_sh shifts right; a_sh/b_sh shift right; carry <= cell Cout; cnt++.
  - When cnt==WIDTH-1 on that edge: go to DONE; out_sum <= final sum_sh; out_cout <= cell Cout.
- State DONE:
  - out_valid=1; out_sum and out_cout held stable.
  - On out_valid&&out_ready: go to IDLE; out_valid drops next cycle.
- Latency: out_valid first visible WIDTH cycles after the accepting edge. Throughput is one add per WIDTH+2 cycles minimum, because DONE→IDLE costs one bubble before the next accept.
- in_valid during RUN/DONE is ignored. Operands do not need to be held after acceptance.
- out_ready while not in DONE has no effect. out_ready may be held high permanently; the result is still presented for exactly one cycle.
- Arithmetic is modulo 2^WIDTH; out_cout is the true carry of the WIDTH-bit sum, with no overflow/sign flag. Cell outputs are purely combinational; all state is in this block.
- rst asserted mid-RUN or mid-DONE: operation aborted, result discarded, all outputs at reset values immediately (asynchronous).
- in_ready, out_valid and busy are decoded from the registered state only; there are no combinational input→output paths.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined: in_sub=1 at accept computes in_a - in_b as in_a + ~in_b + 1; in_cin is ignored for that operation. out_cout=1 means no borrow.
- Undefined: in_sub is ignored; all operations are additions using in_cin.

Decomposition:
- Shared package serial_add_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default WIDTH constant;
  - CNT_W derivation function.
- One sub-module, fa_cell: a 1-bit generate/propagate full adder, instantiated once.

Test Plan (WIDTH=8):
- Basic add: in_a=0x5A, in_b=0x3C, in_cin=0. Expect out_sum=0x96, out_cout=0, out_valid exactly 8 cycles after accept, busy high throughout.
- Wrap-around: 0xFF+0x01, cin=0 → out_sum=0x00, out_cout=1. Also 0xFF+0xFF, cin=1 → out_sum=0xFF, out_cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE; out_sum/out_cout stay stable and in_ready stays 0. Raising out_ready gives one transfer, then in_ready=1 next cycle.
- Busy rejection: pulse in_valid with 0x11/0x22 during RUN. Expect no effect; the first operation's result is unchanged.
- Reset mid-RUN: assert rst at bit 4 of 0xAA+0x55. Outputs go to 0 and in_ready=1 at once; a new 0x01+0x01 then yields 0x02.
- With SERIAL_ADD_SUB_EN: in_sub=1, 0x10-0x01 → 0x0F, cout=1; 0x00-0x01 → 0xFF, cout=0.
